// File: rtl/mul_div_unit_pkg.sv
// Shared ALU-op codes and MDU state/iteration constants.
// Imported by the decoder-facing MDU and its divider core.
package mul_div_unit_pkg;

  localparam int ALUOP_W = 4;

  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD    = 4'd0,
    ALUOP_SUB    = 4'd1,
    ALUOP_AND    = 4'd2,
    ALUOP_OR     = 4'd3,
    ALUOP_XOR    = 4'd4,
    ALUOP_NOR    = 4'd5,
    ALUOP_SLT    = 4'd6,
    ALUOP_SLTU   = 4'd7,
    ALUOP_SLL    = 4'd8,
    ALUOP_SRL    = 4'd9,
    ALUOP_SRA    = 4'd10,
    ALUOP_LUI    = 4'd11,
    ALUOP_TIMES  = 4'd12,
    ALUOP_TIMESU = 4'd13,
    ALUOP_DIV    = 4'd14,
    ALUOP_DIVU   = 4'd15
  } ALUOP_T;

  typedef enum logic [1:0] {
    MDU_ST_IDLE = 2'd0,
    MDU_ST_MUL  = 2'd1,
    MDU_ST_DIV  = 2'd2,
    MDU_ST_FIX  = 2'd3
  } mdu_state_t;

  localparam int MDU_CNT_W = 6;
  localparam int MDU_ITERS = 32;

endpackage

// File: rtl/mdu_div_core.sv
// Unsigned restoring divider: one quotient bit per step, result after WIDTH steps.
// No flow control; the owner sequences load/step and holds results until the next load.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] dsr;
  logic [WIDTH:0]   trial;

  // Top bit of the trial difference is the borrow: set means the divisor did not fit.
  assign trial = {remainder, quotient[WIDTH-1]} - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (rst) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dsr       <= divisor;
    end else if (step) begin
      if (!trial[WIDTH]) begin
        remainder <= trial[WIDTH-1:0];
        quotient  <= {quotient[WIDTH-2:0], 1'b1};
      end else begin
        remainder <= {remainder[WIDTH-2:0], quotient[WIDTH-1]};
        quotient  <= {quotient[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; result 33 cycles after start, busy stalls issue meanwhile.
// MDU_FAST_MULT_EN selects a single-cycle multiplier (multiplies never raise busy); divides unchanged.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  ALUOP_T           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             writeHi,
  input  logic             writeLo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [MDU_CNT_W-1:0] LAST = MDU_CNT_W'(WIDTH - 1);

  mdu_state_t           state;
  logic [MDU_CNT_W-1:0] cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     mcand, rawA, quo, rem;
  logic                 negRes, remNeg, divZero, opIsDiv, fastPend;

  logic             isMul, isDiv, isSigned, aNeg, bNeg, accept;
  logic [WIDTH-1:0] aMag, bMag;
  logic [WIDTH:0]   addHi;

  assign isMul    = (op == ALUOP_TIMES) || (op == ALUOP_TIMESU);
  assign isDiv    = (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  assign isSigned = (op == ALUOP_TIMES) || (op == ALUOP_DIV);
  assign aNeg     = isSigned & a[WIDTH-1];
  assign bNeg     = isSigned & b[WIDTH-1];
  assign aMag     = aNeg ? -a : a;
  assign bMag     = bNeg ? -b : b;
  assign accept   = start && (isMul || isDiv) && (state == MDU_ST_IDLE) && !fastPend;
  assign busy     = (state != MDU_ST_IDLE);

  // Multiplier sits in the low half of prod and shifts out as the product shifts in.
  assign addHi = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, mcand};

  mdu_div_core #(.WIDTH(WIDTH)) divCore (
    .clk      (clk),
    .rst      (rst),
    .load     (accept && isDiv),
    .step     (state == MDU_ST_DIV),
    .dividend (aMag),
    .divisor  (bMag),
    .quotient (quo),
    .remainder(rem)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= MDU_ST_IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      prod     <= '0;
      mcand    <= '0;
      rawA     <= '0;
      negRes   <= 1'b0;
      remNeg   <= 1'b0;
      divZero  <= 1'b0;
      opIsDiv  <= 1'b0;
      fastPend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MDU_ST_IDLE: begin
          if (fastPend) begin
            {hi, lo} <= negRes ? -prod : prod;
            done     <= 1'b1;
            fastPend <= 1'b0;
          end else if (accept) begin
            mcand   <= aMag;
            rawA    <= a;
            negRes  <= aNeg ^ bNeg;
            remNeg  <= aNeg;
            divZero <= (b == '0);
            opIsDiv <= isDiv;
            cnt     <= '0;
            prod    <= {{WIDTH{1'b0}}, bMag};
            if (isDiv) begin
              state <= MDU_ST_DIV;
            end else begin
`ifdef MDU_FAST_MULT_EN
              prod     <= aMag * bMag;
              fastPend <= 1'b1;
`else
              state    <= MDU_ST_MUL;
`endif
            end
          end else begin
            if (writeHi) hi <= wdata;
            if (writeLo) lo <= wdata;
          end
        end
        MDU_ST_MUL: begin
          prod <= prod[0] ? {addHi, prod[WIDTH-1:1]} : {1'b0, prod[2*WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= MDU_ST_FIX;
        end
        MDU_ST_DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= MDU_ST_FIX;
        end
        MDU_ST_FIX: begin
          if (opIsDiv) begin
            if (divZero) begin
              lo <= '1;
              hi <= rawA;
            end else begin
              lo <= negRes ? -quo : quo;
              hi <= remNeg ? -rem : rem;
            end
          end else begin
            {hi, lo} <= negRes ? -prod : prod;
          end
          done  <= 1'b1;
          state <= MDU_ST_IDLE;
        end
        default: state <= MDU_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized + directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
`timescale 1ns/1ps
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        writeHi = 1'b0;
  logic        writeLo = 1'b0;
  ALUOP_T      op = ALUOP_ADD;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int nVec = 0;
  int nErr = 0;
  bit chkEn = 1'b0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .writeHi(writeHi), .writeLo(writeLo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit isMdu(input ALUOP_T o);
    return (o == ALUOP_TIMES) || (o == ALUOP_TIMESU) || (o == ALUOP_DIV) || (o == ALUOP_DIVU);
  endfunction

  // Architectural result of one MDU op, from integer arithmetic.
  task automatic refOp(input ALUOP_T o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl);
    logic [63:0] p;
    int sx, sy;
    sx = x;
    sy = y;
    rh = '0;
    rl = '0;
    case (o)
      ALUOP_TIMES: begin
        p = 64'(longint'(sx) * longint'(sy));
        rh = p[63:32];
        rl = p[31:0];
      end
      ALUOP_TIMESU: begin
        p = {32'b0, x} * {32'b0, y};
        rh = p[63:32];
        rl = p[31:0];
      end
      ALUOP_DIVU: begin
        if (y == 0) begin rl = '1; rh = x; end
        else begin rl = x / y; rh = x % y; end
      end
      ALUOP_DIV: begin
        if (y == 0) begin rl = '1; rh = x; end
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin rl = x; rh = '0; end
        else begin rl = sx / sy; rh = sx % sy; end
      end
      default: ;
    endcase
  endtask

  int          mCnt = 0;
  bit          mFast = 1'b0;
  logic        mDone = 1'b0;
  logic [31:0] mHi = '0, mLo = '0, pHi = '0, pLo = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mCnt = 0; mDone = 1'b0; mHi = '0; mLo = '0; mFast = 1'b0;
    end else begin
      mDone = 1'b0;
      if (mCnt > 0) begin
        mCnt = mCnt - 1;
        if (mCnt == 0) begin mHi = pHi; mLo = pLo; mDone = 1'b1; end
      end else if (start && isMdu(op)) begin
        refOp(op, a, b, pHi, pLo);
`ifdef MDU_FAST_MULT_EN
        mFast = (op == ALUOP_TIMES) || (op == ALUOP_TIMESU);
`else
        mFast = 1'b0;
`endif
        mCnt = mFast ? 1 : MDU_ITERS + 1;
      end else begin
        if (writeHi) mHi = wdata;
        if (writeLo) mLo = wdata;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chkEn) begin
      chk("busy", {31'b0, busy}, {31'b0, (mCnt != 0) && !mFast});
      chk("done", {31'b0, done}, {31'b0, mDone});
      chk("hi", hi, mHi);
      chk("lo", lo, mLo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input ALUOP_T o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(input string nm, output int nBusy);
    nBusy = 0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) return;
      if (busy === 1'b1) nBusy++;
      tick();
    end
    chk({nm, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  int     nb;
  ALUOP_T ro;

  initial begin
    @(posedge clk);
    #1;
    chkEn = 1'b1;
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    rst = 1'b0;
    tick();

    issue(ALUOP_TIMES, 32'hFFFF_FFFF, 32'd5);
    waitDone("mult", nb);
`ifndef MDU_FAST_MULT_EN
    chk("mult_busy_cycles", nb, MDU_ITERS + 1);
`endif
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFB);
    tick();
    chk("mult_done_pulse", {31'b0, done}, 32'd0);

    issue(ALUOP_TIMESU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    waitDone("multu", nb);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(ALUOP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div", nb);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(ALUOP_DIVU, 32'd7, 32'd0);
    waitDone("divz", nb);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_hi", hi, 32'd7);

    issue(ALUOP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("ovf", nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    issue(ALUOP_DIVU, 32'd100, 32'd7);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    waitDone("b2b", nb);
    chk("b2b_lo", lo, 32'd14);
    chk("b2b_hi", hi, 32'd2);

    writeLo = 1'b1; wdata = 32'h1234;
    tick();
    writeLo = 1'b0;
    chk("mtlo", lo, 32'h1234);

    issue(ALUOP_DIVU, 32'd50, 32'd5);
    writeHi = 1'b1; wdata = 32'hAA;
    repeat (5) tick();
    writeHi = 1'b0;
    waitDone("mthi_busy", nb);
    chk("mthi_busy_hi", hi, 32'd0);
    chk("mthi_busy_lo", lo, 32'd10);

    writeLo = 1'b1; wdata = 32'h5555;
    issue(ALUOP_TIMESU, 32'd3, 32'd4);
    writeLo = 1'b0;
    waitDone("start_wins", nb);
    chk("start_wins_lo", lo, 32'd12);

    issue(ALUOP_DIV, 32'd1000, 32'd3);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    tick();

`ifdef MDU_FAST_MULT_EN
    issue(ALUOP_TIMES, 32'd3, 32'd4);
    chk("fast_busy", {31'b0, busy}, 32'd0);
    tick();
    chk("fast_lo", lo, 32'd12);
    chk("fast_done", {31'b0, done}, 32'd1);
    tick();
`endif

    for (int t = 0; t < 40; t++) begin
      ro = ALUOP_T'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        writeHi = 1'($urandom_range(0, 1));
        writeLo = 1'($urandom_range(0, 1));
        wdata   = $urandom;
      end
      issue(ro, pick(), pick());
      writeHi = 1'b0;
      writeLo = 1'b0;
      if (isMdu(ro)) begin
        if ($urandom_range(0, 1) == 1) begin
          repeat ($urandom_range(1, 10)) tick();
          if (busy === 1'b1) issue(ALUOP_DIVU, $urandom, $urandom);
        end
        waitDone("rand", nb);
        tick();
      end else begin
        tick();
      end
    end

    tick();
    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle multiply/divide unit with the architectural HI/LO registers, sitting in the execute stage directly downstream of the instruction decoder. It consumes the decoder's ALU operation code and the two register operands. It executes MULT, MULTU, DIV and DIVU iteratively, and holds the pipeline via `busy` until HI/LO are valid. It also services MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO.

## Interface
Parameters:
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: issue request; qualified by `op`.
- `op`  in  `ALUOP_T`: decoder operation code; only `ALUOP_TIMES`, `ALUOP_TIMESU`, `ALUOP_DIV` and `ALUOP_DIVU` act.
- `a`  in  WIDTH: rs operand (multiplicand / dividend).
- `b`  in  WIDTH: rt operand (multiplier / divisor).
- `writeHi`  in  1: MTHI.
- `writeLo`  in  1: MTLO.
- `wdata`  in  WIDTH: MTHI/MTLO data.
- `busy`  out  1: operation in flight; the pipeline stalls any MDU instruction while this is high.
- `done`  out  1: one-cycle pulse when HI/LO are updated.
- `hi`  out  WIDTH: HI register.
- `lo`  out  WIDTH: LO register.

## Operation
- States are IDLE, MUL, DIV, FIX. `busy` = (state != IDLE).
- In IDLE, `start` with a MDU op:
  - Latch |a| and |b|, taking magnitudes only for the signed ops.
  - Latch sign flags.
  - Clear the 6-bit iteration counter.
  - Go to MUL or DIV.
- `start` with any other op is ignored.
- MUL: radix-2 shift-add on magnitudes, one bit per cycle. After 32 iterations, go to FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle. After 32 iterations, go to FIX.
- FIX, one cycle, then IDLE:
  - Signed multiply: negate the 64-bit product if the operand signs differ. HI = upper half, LO = lower half.
  - Signed divide: LO = quotient, negated if the signs differ. HI = remainder, taking the sign of the dividend.
- Divide by zero, both signednesses: LO = 0xFFFFFFFF, HI = dividend (raw `a`).
- 0x80000000 / 0xFFFFFFFF signed: LO = 0x80000000, HI = 0. This falls out of the magnitude datapath with no special case.
- MTHI/MTLO:
  - Write HI/LO in IDLE only.
  - While busy, the write is ignored. The decoder/stall logic prevents this case; it is defined here for verification.
- `start` and `writeHi`/`writeLo` in the same IDLE cycle: `start` wins and the write is dropped.
- `start` while busy is ignored. No queueing.

## Timing
- Reset values: state IDLE, `busy` 0, `done` 0, `hi` 0, `lo` 0, counter 0.
- `start` sampled at edge k:
  - `busy` is high after edges k..k+32 (33 cycles).
  - HI/LO are written at edge k+33.
  - `done` is high for exactly the cycle after k+33.
- A new `start` is accepted in the `done` cycle, giving back-to-back throughput of one op per 34 cycles.
- `hi`/`lo` are direct register outputs with zero read latency. MFHI in the `done` cycle sees the new value.
- MTHI/MTLO: the value is visible on `hi`/`lo` the cycle after the write edge.
- `rst` mid-operation: abort at that edge. All outputs return to reset values and partial results are discarded.

## Configuration
- `MDU_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle 32x32 multiplier.
  - The result is written at edge k+1, `done` pulses in the following cycle, and `busy` is never asserted for multiplies.
  - Divides are unchanged.
- `MDU_FAST_MULT_EN` undefined: iterative multiply as above.
- Results are bit-identical in both builds.

## Structure
- Shared header: the `ALUOP_*` codes and the `ALUOP_T` width from the existing ALU-op header, plus the new MDU state encodings (`MDU_ST_*`) and the iteration count constant.
- One sub-module, `mdu_div_core`: the unsigned restoring-divider datapath (remainder/quotient shift registers, subtract-compare). The FSM, sign handling, multiply path and HI/LO stay in `mul_div_unit`.

## Test plan
- MULT a=0xFFFFFFFF, b=5 -> after 33 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFFB, `done` one cycle.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0; back-to-back DIVU issued in the `done` cycle is accepted.
- MTLO 0x1234 in IDLE -> `lo`=0x1234 next cycle; MTHI 0xAA during busy -> ignored, HI holds the final result.
- `rst` at cycle 10 of a DIV -> next cycle `busy`=0, `done`=0, HI=LO=0; under `MDU_FAST_MULT_EN`, MULT 3x4 -> LO=12 at edge k+1, `busy` never high.
